// File: rtl/pc_reg_if.sv
// pc_reg_if: fetch-control bundle between the pipeline controller/ID stage and the PC register.
interface pc_reg_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [5:0]            stall;
    logic                  branch_flag_i;
    logic [ADDR_WIDTH-1:0] branch_target_address_i;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  ce;

    modport master (
        output stall, branch_flag_i, branch_target_address_i,
        input  pc, ce
    );

    modport slave (
        input  stall, branch_flag_i, branch_target_address_i,
        output pc, ce
    );
endinterface

// File: rtl/pc_reg.sv
// pc_reg: IF-stage program counter; advances by PC_STEP, loads branch targets, holds on stall[0].
module pc_reg #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4
) (
    input logic    clk,
    input logic    rst,
    pc_reg_if.slave bus
);
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  ce_q, ce_d;

    // ce_q lags reset release by one edge, so RESET_PC is fetched exactly once.
    always_comb begin
        ce_d = 1'b1;
        pc_d = !ce_q         ? RESET_PC :
               bus.stall[0]  ? pc_q :
               bus.branch_flag_i ? bus.branch_target_address_i :
                               pc_q + ADDR_WIDTH'(PC_STEP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_q <= 1'b0;
            pc_q <= RESET_PC;
        end else begin
            ce_q <= ce_d;
            pc_q <= pc_d;
        end
    end

    assign bus.pc = pc_q;
    assign bus.ce = ce_q;
endmodule

// File: tb/tb_pc_reg.sv
// tb_pc_reg: directed checks of reset, stall priority, branching and wrap-around.
module tb_pc_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    pc_reg_if #(.ADDR_WIDTH(32)) bus ();

    pc_reg #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [3] = '{32'd4, 32'd8, 32'd12};
        rst = 1'b1;
        bus.stall = 6'b0;
        bus.branch_flag_i = 1'b0;
        bus.branch_target_address_i = 32'h0;
        repeat (10) tick();
        total++;
        if (bus.ce !== 1'b0) begin bad++; $display("FAIL reset_ce got=%b exp=0", bus.ce); end
        total++;
        if (bus.pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", bus.pc); end
        rst = 1'b0;
        tick();
        total++;
        if (bus.ce !== 1'b1) begin bad++; $display("FAIL first_edge_ce got=%b exp=1", bus.ce); end
        total++;
        if (bus.pc !== 32'h0) begin bad++; $display("FAIL first_edge_pc got=%h exp=0", bus.pc); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.pc !== exp_seq[i]) begin bad++; $display("FAIL startup_seq%0d got=%h exp=%h", i, bus.pc, exp_seq[i]); end
        end
    endtask

    task automatic test_async_reset();
        tick();
        total++;
        if (bus.pc !== 32'h10) begin bad++; $display("FAIL pre_async_pc got=%h exp=10", bus.pc); end
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.ce !== 1'b0) begin bad++; $display("FAIL async_ce got=%b exp=0", bus.ce); end
        total++;
        if (bus.pc !== 32'h0) begin bad++; $display("FAIL async_pc got=%h exp=0", bus.pc); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++;
        if (bus.pc !== 32'h0 || bus.ce !== 1'b1) begin bad++; $display("FAIL async_release got=%h/%b exp=0/1", bus.pc, bus.ce); end
        tick();
        tick();
        total++;
        if (bus.pc !== 32'h8) begin bad++; $display("FAIL async_resume got=%h exp=8", bus.pc); end
    endtask

    task automatic test_stall_branch();
        bus.stall = 6'b000111;
        bus.branch_flag_i = 1'b1;
        bus.branch_target_address_i = 32'h10;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) bus.stall = 6'b000001;
            tick();
            total++;
            if (bus.pc !== 32'h8) begin bad++; $display("FAIL stall_hold%0d got=%h exp=8", i, bus.pc); end
        end
        bus.stall = 6'b0;
        bus.branch_flag_i = 1'b0;
        tick();
        total++;
        if (bus.pc !== 32'hC) begin bad++; $display("FAIL stall_resume0 got=%h exp=c", bus.pc); end
        tick();
        total++;
        if (bus.pc !== 32'h10) begin bad++; $display("FAIL stall_resume1 got=%h exp=10", bus.pc); end
    endtask

    task automatic test_branch();
        bus.branch_flag_i = 1'b1;
        bus.branch_target_address_i = 32'h1000;
        tick();
        total++;
        if (bus.pc !== 32'h1000) begin bad++; $display("FAIL branch_load got=%h exp=1000", bus.pc); end
        bus.branch_flag_i = 1'b0;
        tick();
        total++;
        if (bus.pc !== 32'h1004) begin bad++; $display("FAIL branch_next0 got=%h exp=1004", bus.pc); end
        tick();
        total++;
        if (bus.pc !== 32'h1008) begin bad++; $display("FAIL branch_next1 got=%h exp=1008", bus.pc); end
    endtask

    task automatic test_held_branch();
        bus.branch_flag_i = 1'b1;
        bus.branch_target_address_i = 32'h1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.pc !== 32'h1000) begin bad++; $display("FAIL held_branch%0d got=%h exp=1000", i, bus.pc); end
        end
        bus.branch_flag_i = 1'b0;
        tick();
        total++;
        if (bus.pc !== 32'h1004) begin bad++; $display("FAIL stale_target got=%h exp=1004", bus.pc); end
    endtask

    task automatic test_wrap();
        bus.branch_flag_i = 1'b1;
        bus.branch_target_address_i = 32'hFFFF_FFFC;
        tick();
        total++;
        if (bus.pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_load got=%h exp=fffffffc", bus.pc); end
        bus.branch_flag_i = 1'b0;
        tick();
        total++;
        if (bus.pc !== 32'h0) begin bad++; $display("FAIL wrap_zero got=%h exp=0", bus.pc); end
        tick();
        total++;
        if (bus.pc !== 32'h4) begin bad++; $display("FAIL wrap_four got=%h exp=4", bus.pc); end
        total++;
        if (bus.ce !== 1'b1) begin bad++; $display("FAIL wrap_ce got=%b exp=1", bus.ce); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_async_reset();
        test_stall_branch();
        test_branch();
        test_held_branch();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
